// File: rtl/load_store_unit.sv
// Load/store unit between execute and data memory: one request at a time, aligned
// accesses in a single cycle, misaligned halfword/word accesses split into byte accesses.
module load_store_unit #(
    parameter bit ALLOW_MISALIGNED = 1'b1,
    parameter int MEM_BYTES        = 800
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_width,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        dm_write_enable,
    output logic [2:0]  dm_mem_width,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_write_data,
    input  logic [31:0] dm_read_data
);

    typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP} state_t;

    state_t      state_reg;
    logic        store_reg;
    logic [2:0]  width_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [1:0]  k_reg;
    logic [1:0]  last_k_reg;
    logic [31:0] asm_reg;

    logic        width_ok;
    logic [2:0]  nbytes;
    logic        misaligned;
    logic        range_err;
    logic        req_err;
    logic [32:0] last_byte;
    logic [1:0]  k_next;
    logic [31:0] asm_next;
    logic [31:0] split_result;

    assign req_ready = (state_reg == IDLE) && !reset;

    // Request classification, evaluated on the live request fields at acceptance.
    always_comb begin
        width_ok = 1'b1;
        nbytes   = 3'd1;
        case (req_width)
            3'b000, 3'b100: nbytes = 3'd1;
            3'b001, 3'b101: nbytes = 3'd2;
            3'b010:         nbytes = 3'd4;
            default:        width_ok = 1'b0;
        endcase
        misaligned = ((req_width[1:0] == 2'b01) && req_addr[0])
                   || ((req_width == 3'b010) && (req_addr[1:0] != 2'b00));
        last_byte  = {1'b0, req_addr} + {30'd0, nbytes} - 33'd1;
        range_err  = last_byte >= 33'(MEM_BYTES);
        req_err    = !width_ok || range_err || (misaligned && !ALLOW_MISALIGNED);
    end

    // Byte assembly for split loads; the final byte is merged before extension.
    always_comb begin
        k_next   = k_reg + 2'd1;
        asm_next = asm_reg;
        asm_next[{k_reg, 3'b000} +: 8] = dm_read_data[7:0];
        case (width_reg)
            3'b001:  split_result = {{16{asm_next[15]}}, asm_next[15:0]};
            3'b101:  split_result = {16'd0, asm_next[15:0]};
            default: split_result = asm_next;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            store_reg       <= 1'b0;
            width_reg       <= 3'd0;
            addr_reg        <= 32'd0;
            wdata_reg       <= 32'd0;
            k_reg           <= 2'd0;
            last_k_reg      <= 2'd0;
            asm_reg         <= 32'd0;
            resp_valid      <= 1'b0;
            resp_err        <= 1'b0;
            resp_rdata      <= 32'd0;
            dm_write_enable <= 1'b0;
            dm_mem_width    <= 3'd0;
            dm_addr         <= 32'd0;
            dm_write_data   <= 32'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'd0;
                    if (req_valid) begin
                        store_reg  <= req_store;
                        width_reg  <= req_width;
                        addr_reg   <= req_addr;
                        wdata_reg  <= req_wdata;
                        k_reg      <= 2'd0;
                        last_k_reg <= 2'(nbytes - 3'd1);
                        asm_reg    <= 32'd0;
                        if (req_err) begin
                            state_reg  <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (misaligned) begin
                            state_reg       <= SPLIT;
                            dm_write_enable <= req_store;
                            dm_mem_width    <= req_store ? 3'b000 : 3'b100;
                            dm_addr         <= req_addr;
                            dm_write_data   <= {24'd0, req_wdata[7:0]};
                        end else begin
                            state_reg       <= ACCESS;
                            dm_write_enable <= req_store;
                            dm_mem_width    <= req_width;
                            dm_addr         <= req_addr;
                            dm_write_data   <= req_wdata;
                        end
                    end
                end
                ACCESS: begin
                    state_reg       <= RESP;
                    resp_valid      <= 1'b1;
                    resp_err        <= 1'b0;
                    resp_rdata      <= store_reg ? 32'd0 : dm_read_data;
                    dm_write_enable <= 1'b0;
                    dm_mem_width    <= 3'd0;
                    dm_addr         <= 32'd0;
                    dm_write_data   <= 32'd0;
                end
                SPLIT: begin
                    asm_reg <= asm_next;
                    if (k_reg == last_k_reg) begin
                        state_reg       <= RESP;
                        resp_valid      <= 1'b1;
                        resp_err        <= 1'b0;
                        resp_rdata      <= store_reg ? 32'd0 : split_result;
                        dm_write_enable <= 1'b0;
                        dm_mem_width    <= 3'd0;
                        dm_addr         <= 32'd0;
                        dm_write_data   <= 32'd0;
                    end else begin
                        k_reg         <= k_next;
                        dm_addr       <= addr_reg + {30'd0, k_next};
                        dm_write_data <= {24'd0, wdata_reg[{k_next, 3'b000} +: 8]};
                    end
                end
                RESP: begin
                    state_reg  <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'd0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench: two units (misaligned split enabled / disabled) share one request stream,
// each with its own byte-array data memory; results are compared to a byte-level model.
module tb_load_store_unit;

    localparam int MEM = 800;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_store = 1'b0;
    logic [2:0]  req_width = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;

    logic        req_ready [2];
    logic        resp_valid [2];
    logic        resp_err [2];
    logic [31:0] resp_rdata [2];
    logic        dm_we [2];
    logic [2:0]  dm_mem_width [2];
    logic [31:0] dm_addr [2];
    logic [31:0] dm_write_data [2];
    logic [31:0] dm_read_data [2];

    logic [7:0]  ref_m [2][MEM];
    int          n_checks = 0;
    int          n_pass = 0;
    logic        last_err [2];
    logic [31:0] last_rd [2];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        logic [7:0] mem [0:MEM-1];
        int         wr_cnt = 0;

        load_store_unit #(.ALLOW_MISALIGNED(gi == 0), .MEM_BYTES(MEM)) u_dut (
            .clk(clk), .reset(reset),
            .req_valid(req_valid), .req_ready(req_ready[gi]),
            .req_store(req_store), .req_width(req_width),
            .req_addr(req_addr), .req_wdata(req_wdata),
            .resp_valid(resp_valid[gi]), .resp_err(resp_err[gi]), .resp_rdata(resp_rdata[gi]),
            .dm_write_enable(dm_we[gi]), .dm_mem_width(dm_mem_width[gi]),
            .dm_addr(dm_addr[gi]), .dm_write_data(dm_write_data[gi]),
            .dm_read_data(dm_read_data[gi])
        );

        function automatic logic [7:0] byte_at(input logic [31:0] a);
            return (a < MEM) ? mem[a[9:0]] : 8'h00;
        endfunction

        // Data memory: combinational little-endian read with width extension.
        always_comb begin
            logic [31:0] w;
            w = {byte_at(dm_addr[gi] + 3), byte_at(dm_addr[gi] + 2),
                 byte_at(dm_addr[gi] + 1), byte_at(dm_addr[gi])};
            case (dm_mem_width[gi])
                3'b000:  dm_read_data[gi] = {{24{w[7]}}, w[7:0]};
                3'b100:  dm_read_data[gi] = {24'd0, w[7:0]};
                3'b001:  dm_read_data[gi] = {{16{w[15]}}, w[15:0]};
                3'b101:  dm_read_data[gi] = {16'd0, w[15:0]};
                3'b010:  dm_read_data[gi] = w;
                default: dm_read_data[gi] = 32'd0;
            endcase
        end

        initial for (int j = 0; j < MEM; j++) mem[j] <= 8'h00;

        always @(negedge clk) begin
            if (dm_we[gi]) begin
                int n;
                wr_cnt <= wr_cnt + 1;
                case (dm_mem_width[gi])
                    3'b001, 3'b101: n = 2;
                    3'b010:         n = 4;
                    default:        n = 1;
                endcase
                for (int i = 0; i < n; i++)
                    if (dm_addr[gi] + i < MEM) mem[dm_addr[gi] + i] <= dm_write_data[gi][8*i +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h expected=%h", tag, got, exp);
    endtask

    // Reference: whole-access view (n bytes at addr, little-endian), no notion of states.
    task automatic model(input int d, input logic st, input logic [2:0] w, input logic [31:0] a,
                         input logic [31:0] wd, output logic err, output logic [31:0] rd,
                         output int lat, output int wr);
        int n; bit legal; bit mis; longint last; logic [31:0] v;
        legal = 1; n = 1;
        case (w)
            3'b000, 3'b100: n = 1;
            3'b001, 3'b101: n = 2;
            3'b010:         n = 4;
            default:        legal = 0;
        endcase
        mis  = (a % n) != 0;
        last = longint'(a) + n - 1;
        err  = !legal || (last >= MEM) || (mis && d == 1);
        rd = 0; wr = 0; lat = 1;
        if (!err) begin
            lat = mis ? n + 1 : 2;
            if (st) begin
                wr = mis ? n : 1;
                for (int i = 0; i < n; i++) ref_m[d][a + i] = wd[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < n; i++) v = v | (32'(ref_m[d][a + i]) << (8 * i));
                case (w)
                    3'b000:  rd = {{24{v[7]}}, v[7:0]};
                    3'b001:  rd = {{16{v[15]}}, v[15:0]};
                    default: rd = v;
                endcase
            end
        end
    endtask

    task automatic do_txn(input logic st, input logic [2:0] w, input logic [31:0] a, input logic [31:0] wd);
        logic e_err [2]; logic [31:0] e_rd [2]; int e_lat [2]; int e_wr [2];
        int wc0 [2]; int got_lat [2]; logic done [2];
        for (int d = 0; d < 2; d++) begin
            model(d, st, w, a, wd, e_err[d], e_rd[d], e_lat[d], e_wr[d]);
            done[d] = 0; got_lat[d] = 0; last_err[d] = 1'bx; last_rd[d] = 'x;
        end
        wc0[0] = g_dut[0].wr_cnt; wc0[1] = g_dut[1].wr_cnt;
        req_store = st; req_width = w; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        chk("ready_a", 32'(req_ready[0]), 1);
        chk("ready_b", 32'(req_ready[1]), 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr = $urandom; req_wdata = $urandom; req_width = 3'($urandom); req_store = 1'($urandom);
        for (int cyc = 1; cyc <= 12 && !(done[0] && done[1]); cyc++) begin
            for (int d = 0; d < 2; d++) begin
                if (!done[d] && resp_valid[d]) begin
                    done[d] = 1; got_lat[d] = cyc; last_err[d] = resp_err[d]; last_rd[d] = resp_rdata[d];
                end
            end
            if (!(done[0] && done[1])) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("pulse%0d", d), 32'(resp_valid[d]), 0);
            chk($sformatf("lat%0d", d), got_lat[d], e_lat[d]);
            chk($sformatf("err%0d", d), 32'(last_err[d]), 32'(e_err[d]));
            chk($sformatf("rdata%0d", d), last_rd[d], e_rd[d]);
        end
        chk("writes0", g_dut[0].wr_cnt - wc0[0], e_wr[0]);
        chk("writes1", g_dut[1].wr_cnt - wc0[1], e_wr[1]);
        $display("txn st=%0d w=%03b a=%h wd=%h | a: lat=%0d err=%0d rd=%h | b: lat=%0d err=%0d rd=%h",
                 st, w, a, wd, got_lat[0], last_err[0], last_rd[0], got_lat[1], last_err[1], last_rd[1]);
    endtask

    initial begin
        int mm0, mm1, wc_a;
        logic [2:0] wt;
        logic [31:0] at;
        for (int d = 0; d < 2; d++) for (int j = 0; j < MEM; j++) ref_m[d][j] = 8'h00;

        #2 reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", 32'(req_ready[d]), 0);
            chk("rst_valid", 32'(resp_valid[d]), 0);
            chk("rst_err", 32'(resp_err[d]), 0);
            chk("rst_rdata", resp_rdata[d], 0);
            chk("rst_we", 32'(dm_we[d]), 0);
            chk("rst_addr", dm_addr[d], 0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("idle_ready", 32'(req_ready[0]), 1);
        chk("idle_wdata", dm_write_data[0], 0);
        @(posedge clk); #1;

        do_txn(1, 3'b010, 32'h10, 32'hDEADBEEF);
        do_txn(0, 3'b010, 32'h10, 32'h0);
        chk("tp_ldw", last_rd[0], 32'hDEADBEEF);
        do_txn(1, 3'b010, 32'h20, 32'h80FF7F01);
        do_txn(0, 3'b000, 32'h21, 32'h0);
        chk("tp_lb21", last_rd[0], 32'h0000007F);
        do_txn(0, 3'b000, 32'h23, 32'h0);
        chk("tp_lb23", last_rd[0], 32'hFFFFFF80);
        do_txn(0, 3'b100, 32'h23, 32'h0);
        chk("tp_lbu23", last_rd[0], 32'h00000080);
        do_txn(1, 3'b010, 32'h31, 32'h11223344);
        do_txn(0, 3'b010, 32'h31, 32'h0);
        chk("tp_ldw31", last_rd[0], 32'h11223344);
        do_txn(0, 3'b001, 32'h33, 32'h0);
        chk("tp_ldh33", last_rd[0], 32'h00001122);
        do_txn(1, 3'b011, 32'h40, 32'hFFFFFFFF);
        chk("tp_illegal", 32'(last_err[0]), 1);
        do_txn(0, 3'b010, 32'h31C, 32'h0);
        do_txn(0, 3'b010, 32'h318, 32'h0);
        do_txn(0, 3'b010, 32'h31D, 32'h0);
        do_txn(0, 3'b010, 32'h320, 32'h0);
        do_txn(0, 3'b001, 32'h31F, 32'h0);
        do_txn(0, 3'b101, 32'h31E, 32'h0);
        do_txn(0, 3'b010, 32'hFFFFFFFE, 32'h0);
        do_txn(0, 3'b001, 32'h41, 32'h0);
        chk("tp_nomis", 32'(last_err[1]), 1);

        // Reset during the second byte of a split word store at 0x51.
        do_txn(1, 3'b010, 32'h50, 32'h5A5A5A5A);
        do_txn(1, 3'b000, 32'h54, 32'h00000077);
        wc_a = g_dut[0].wr_cnt;
        req_store = 1; req_width = 3'b010; req_addr = 32'h51; req_wdata = 32'hA1B2C3D4; req_valid = 1;
        @(posedge clk); #1;
        req_valid = 0;
        chk("rs_b_valid", 32'(resp_valid[1]), 1);
        chk("rs_b_err", 32'(resp_err[1]), 1);
        chk("rs_a_addr0", dm_addr[0], 32'h51);
        @(posedge clk); #1;
        chk("rs_a_addr1", dm_addr[0], 32'h52);
        @(negedge clk); #1;
        reset = 1'b1;
        #1;
        chk("rs_valid", 32'(resp_valid[0]), 0);
        chk("rs_we", 32'(dm_we[0]), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("rs_ready", 32'(req_ready[0]), 1);
        repeat (3) begin
            @(posedge clk); #1;
            chk("rs_noresp", 32'(resp_valid[0]), 0);
        end
        chk("rs_writes", g_dut[0].wr_cnt - wc_a, 2);
        chk("rs_m51", 32'(g_dut[0].mem[32'h51]), 32'hD4);
        chk("rs_m52", 32'(g_dut[0].mem[32'h52]), 32'hC3);
        chk("rs_m53", 32'(g_dut[0].mem[32'h53]), 32'h5A);
        chk("rs_m54", 32'(g_dut[0].mem[32'h54]), 32'h77);
        ref_m[0][32'h51] = 8'hD4;
        ref_m[0][32'h52] = 8'hC3;
        $display("txn reset-abort split store a=00000051 done");

        for (int t = 0; t < 200; t++) begin
            if ($urandom_range(0, 9) == 0) wt = 3'($urandom_range(0, 7));
            else case ($urandom_range(0, 4))
                0: wt = 3'b000; 1: wt = 3'b001; 2: wt = 3'b010; 3: wt = 3'b100; default: wt = 3'b101;
            endcase
            at = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(780, 830)) : 32'($urandom_range(0, 127));
            do_txn(1'($urandom_range(0, 1)), wt, at, $urandom);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        mm0 = 0; mm1 = 0;
        for (int j = 0; j < MEM; j++) begin
            if (g_dut[0].mem[j] !== ref_m[0][j]) mm0++;
            if (g_dut[1].mem[j] !== ref_m[1][j]) mm1++;
        end
        chk("mem_a", mm0, 0);
        chk("mem_b", mm1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
